invert_16_bit: RTL and testbench
================================

# invert_16_bit

Registered 16-bit two's-complement negation unit: for each accepted input word A it produces invA = −A (bitwise invert plus one) and flags the single unrepresentable case, A = −32768. It sits in the datapath as a pipelined arithmetic leaf with one cycle of latency and a simple valid handshake. A sticky overflow flag supports status reporting.

## Interface
- No parameters; width is fixed at 16 bits.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: A is valid this cycle.
- `A` input 16: operand, two's complement.
- `ovf_clr` input 1: synchronous clear of `ovf_sticky`.
- `out_valid` output 1: `invA` and `overflow` hold a new result.
- `invA` output 16: −A, two's complement.
- `overflow` output 1: result not representable, i.e. A was 16'h8000.
- `ovf_sticky` output 1: set by any overflowing accepted input; held until reset or `ovf_clr`.

## Operation
- Combinational core: the negated value is ~A + 1, computed by a 16-bit incrementer with a ripple carry. The carry out of bit 15 is discarded.
- Overflow is raised only when A == 16'h8000. The sign of A and the sign of the result are then both 1.
- A == 0 gives 0, with no overflow. The carry out is ignored.
- When `in_valid`=1, the result is captured into `invA`, `overflow` and `out_valid`=1 on the next rising edge.
- When `in_valid`=0, `out_valid` goes to 0 on the next edge. `invA` and `overflow` hold their last values.
- `ovf_sticky`:
  - It is set on the edge that registers an overflowing result.
  - If `ovf_clr` and a new overflow occur in the same cycle, set wins and the flag ends at 1.
  - `ovf_clr` with no new overflow clears it to 0.

## Timing
- Latency is exactly 1 cycle from A/`in_valid` to `invA`/`overflow`/`out_valid`.
- Throughput is one operand per cycle. There is no backpressure.
- Reset values, all applied asynchronously on `rst_n`=0:
  - `invA`=16'h0000
  - `overflow`=0
  - `out_valid`=0
  - `ovf_sticky`=0
- Reset asserted mid-stream drops any in-flight result. The first `out_valid` after reset release appears one cycle after the first accepted `in_valid`.
- All outputs come directly from registers. There is no combinational path from inputs to outputs.

## Configuration
- `INVERT_16BIT_SAT_EN`:
  - When defined, an overflowing input gives saturated `invA`=16'h7FFF. `overflow` is still 1.
  - When undefined, `invA` is the wrapped result 16'h8000 with `overflow`=1.
  - All other inputs behave identically in both builds.

## Structure
- Shared package `invert_pkg`:
  - `WORD_W`=16
  - `word_t` (logic [15:0])
  - constants `WORD_MIN`=16'h8000 and `WORD_MAX`=16'h7FFF
- Sub-module `inc_16bit` is the combinational ripple incrementer.
  - Ports: `a[15:0]`, `sum[15:0]`, `cout`.
  - Built from a per-bit half-adder chain.
  - Top-level instantiates it once, fed with ~A.

## Test plan
- Reset then A=16'h0000, `in_valid`=1 → next cycle `invA`=16'h0000, `overflow`=0, `out_valid`=1.
- A=5 → `invA`=16'hFFFB, `overflow`=0. A=−9 (16'hFFF7) → `invA`=16'h0009, `overflow`=0.
- A=16'h7FFF → `invA`=16'h8001, `overflow`=0, `ovf_sticky` stays 0.
- A=16'h8000:
  - Without the macro, `invA`=16'h8000.
  - With `INVERT_16BIT_SAT_EN`, `invA`=16'h7FFF.
  - In both builds `overflow`=1 and `ovf_sticky`=1.
  - `ovf_sticky` stays 1 on the following non-overflowing inputs until an `ovf_clr` pulse clears it. Clear and overflow in the same cycle leave it at 1.
- Back-to-back stream 0,5,−9,16'h7FFF,16'h8000 with `in_valid` held high:
  - Results appear one per cycle with 1-cycle lag.
  - Dropping `in_valid` gives `out_valid`=0 while `invA` holds 16'h8000.
- Assert `rst_n`=0 asynchronously mid-stream → all outputs go to 0 immediately without waiting for a clock edge. After release, `out_valid` stays 0 until a new input is accepted.

Source files
------------

// File: rtl/invert_pkg.sv
// Shared word type and limits for the 16-bit two's-complement negation unit.
package invert_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t WORD_MIN = 16'h8000;
    localparam word_t WORD_MAX = 16'h7FFF;

    // Only the most negative word has no positive counterpart.
    function automatic logic neg_overflows(input word_t a);
        return (a == WORD_MIN);
    endfunction

endpackage

// File: rtl/inc_16bit.sv
// Combinational 16-bit ripple incrementer (a + 1) built from a half-adder chain.
module inc_16bit
    import invert_pkg::*;
(
    input  logic [15:0] a,
    output logic [15:0] sum,
    output logic        cout
);

    logic [WORD_W:0] carry;

    // The constant carry-in of 1 turns the half-adder chain into a +1.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WORD_W; i++) begin : g_ha
        assign sum[i]     = a[i] ^ carry[i];
        assign carry[i+1] = a[i] & carry[i];
    end

    assign cout = carry[WORD_W];

endmodule

// File: rtl/invert_16_bit.sv
// Registered two's-complement negation (-A = ~A + 1) with overflow and sticky flags.
// Optional build macro INVERT_16BIT_SAT_EN saturates the A = 16'h8000 result to 16'h7FFF.
module invert_16_bit
    import invert_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] A,
    input  logic        ovf_clr,
    output logic        out_valid,
    output logic [15:0] invA,
    output logic        overflow,
    output logic        ovf_sticky
);

    word_t inc_sum;
    word_t result;
    logic  ovf_now;
    logic  cout_unused;

    inc_16bit u_inc (
        .a    (~A),
        .sum  (inc_sum),
        .cout (cout_unused)
    );

    assign ovf_now = neg_overflows(A);

    // NOTE: always_comb assigns a default first so no path through the block can infer a latch.
    always_comb begin
        result = inc_sum;
`ifdef INVERT_16BIT_SAT_EN
        if (ovf_now) begin
            result = WORD_MAX;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            invA       <= '0;
            overflow   <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                invA     <= result;
                overflow <= ovf_now;
            end
            // A fresh overflow takes priority over a simultaneous clear.
            if (in_valid && ovf_now) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_invert_16_bit.sv
// Directed self-checking bench for invert_16_bit; honours INVERT_16BIT_SAT_EN for the A = 16'h8000 case.
module tb_invert_16_bit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] A;
    logic        ovf_clr;
    logic        out_valid;
    logic [15:0] invA;
    logic        overflow;
    logic        ovf_sticky;

    int checks   = 0;
    int failures = 0;

`ifdef INVERT_16BIT_SAT_EN
    localparam logic [15:0] MIN_RESULT = 16'h7FFF;
`else
    localparam logic [15:0] MIN_RESULT = 16'h8000;
`endif

    invert_16_bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .A          (A),
        .ovf_clr    (ovf_clr),
        .out_valid  (out_valid),
        .invA       (invA),
        .overflow   (overflow),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [15:0] a_i, input logic v, input logic clr);
        A        = a_i;
        in_valid = v;
        ovf_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ov, input logic [15:0] ia,
                             input logic of, input logic st);
        check({tag, ".out_valid"},  {31'd0, out_valid},  {31'd0, ov});
        check({tag, ".invA"},       {16'd0, invA},       {16'd0, ia});
        check({tag, ".overflow"},   {31'd0, overflow},   {31'd0, of});
        check({tag, ".ovf_sticky"}, {31'd0, ovf_sticky}, {31'd0, st});
    endtask

    // Back-to-back stream with hand-computed negations.
    logic [15:0] stream_a   [5] = '{16'h0000, 16'h0005, 16'hFFF7, 16'h7FFF, 16'h8000};
    logic [15:0] stream_neg [5] = '{16'h0000, 16'hFFFB, 16'h0009, 16'h8001, MIN_RESULT};
    logic        stream_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        A        = 16'h8000;
        ovf_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        in_valid = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step(stream_a[i], 1'b1, 1'b0);
            check_all($sformatf("stream%0d", i), 1'b1, stream_neg[i], stream_ovf[i], stream_ovf[i]);
        end

        step(16'h1234, 1'b0, 1'b0);
        check_all("idle_hold", 1'b0, MIN_RESULT, 1'b1, 1'b1);

        step(16'h0001, 1'b1, 1'b0);
        check_all("sticky_held", 1'b1, 16'hFFFF, 1'b0, 1'b1);
        step(16'h1234, 1'b1, 1'b0);
        check_all("neg_1234", 1'b1, 16'hEDCC, 1'b0, 1'b1);
        step(16'h0002, 1'b1, 1'b1);
        check_all("clr_no_ovf", 1'b1, 16'hFFFE, 1'b0, 1'b0);
        step(16'h8000, 1'b1, 1'b1);
        check_all("clr_and_ovf", 1'b1, MIN_RESULT, 1'b1, 1'b1);
        step(16'h8001, 1'b1, 1'b0);
        check_all("neg_8001", 1'b1, 16'h7FFF, 1'b0, 1'b1);
        step(16'hFFFF, 1'b0, 1'b1);
        check_all("clr_idle", 1'b0, 16'h7FFF, 1'b0, 1'b0);

        // Asynchronous reset landing between clock edges.
        step(16'h8000, 1'b1, 1'b0);
        check_all("pre_reset", 1'b1, MIN_RESULT, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 16'h0000, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        step(16'h0003, 1'b0, 1'b0);
        check_all("post_reset_idle", 1'b0, 16'h0000, 1'b0, 1'b0);
        step(16'h0003, 1'b1, 1'b0);
        check_all("post_reset_first", 1'b1, 16'hFFFD, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
